// File: rtl/aline_fire_scheduler_pkg.sv
// Shared widths, FSM encoding and the max-delay helper for the A-line fire scheduler.
package aline_sched_pkg;

  localparam int NUM_CH  = 8;
  localparam int DELAY_W = 16;
  localparam int SHAPE_W = 32;
  localparam int T_W     = DELAY_W + 1;
  localparam int IDX_W   = $clog2(SHAPE_W);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_LATCH,
    S_FIRE,
    S_GAP
  } state_t;

  function automatic logic [DELAY_W-1:0] max_delay(input logic [NUM_CH*DELAY_W-1:0] d);
    logic [DELAY_W-1:0] m;
    m = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (d[i*DELAY_W +: DELAY_W] > m) m = d[i*DELAY_W +: DELAY_W];
    end
    return m;
  endfunction

endpackage

// File: rtl/channel_pulse_gen.sv
// One transmit channel: emits the latched pulse shape MSB-first starting when t reaches d.
module channel_pulse_gen
  import aline_sched_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [T_W-1:0]     t,
  input  logic [DELAY_W-1:0] d,
  input  logic [SHAPE_W-1:0] shape_q,
  output logic               tx
);

  logic [T_W-1:0]   d_ext;
  logic [T_W-1:0]   off;
  logic [IDX_W-1:0] sel;
  logic             in_win;

  // Window test is done as (t >= d) and (t - d < SHAPE_W) so d + SHAPE_W never has to be formed.
  assign d_ext  = {1'b0, d};
  assign off    = t - d_ext;
  assign in_win = (t >= d_ext) && (off < T_W'(SHAPE_W));
  assign sel    = IDX_W'(SHAPE_W - 1) - off[IDX_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx <= 1'b0;
    end else begin
      tx <= en && in_win && shape_q[sel];
    end
  end

endmodule

// File: rtl/aline_fire_scheduler.sv
// Frame sequencer: steps A-lines, latches per-line delays and shape, fires all channels, holds the PRI.
module aline_fire_scheduler
  import aline_sched_pkg::*;
#(
  parameter int NUM_ALINES = 16,
  parameter int ALINE_W    = 4,
  parameter int PRI_CYCLES = 1000,
  parameter int LOAD_CYC   = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      abort,
  input  logic                      cfg_busy,
  input  logic [NUM_CH*DELAY_W-1:0] ch_delay,
  input  logic [SHAPE_W-1:0]        pulse_shape,
  output logic [ALINE_W-1:0]        which_aline,
  output logic [NUM_CH-1:0]         tx,
  output logic                      busy,
  output logic                      aline_done,
  output logic                      frame_done
);

  localparam int LC_W   = $clog2(LOAD_CYC + 1);
  localparam int PRI_LW = $clog2(PRI_CYCLES) + 1;
  localparam int PRI_W  = (T_W + 1 > PRI_LW) ? T_W + 1 : PRI_LW;

  state_t                    state, state_nxt;
  logic [T_W-1:0]            t, t_nxt;
  logic [PRI_W-1:0]          pri_cnt;
  logic [LC_W-1:0]           load_cnt;
  logic [NUM_CH*DELAY_W-1:0] d_q;
  logic [SHAPE_W-1:0]        shape_q;
  logic [DELAY_W-1:0]        max_d;
  logic                      load_ok, fire_end, pri_end, last_aline, fire_en;

  assign load_ok    = !cfg_busy && (load_cnt == LC_W'(LOAD_CYC - 1));
  assign fire_end   = (t == {1'b0, max_d} + T_W'(SHAPE_W - 1));
  assign pri_end    = (pri_cnt >= PRI_W'(PRI_CYCLES - 1));
  assign last_aline = (which_aline == ALINE_W'(NUM_ALINES - 1));
  assign busy       = (state != S_IDLE);
  assign fire_en    = (state_nxt == S_FIRE);

  always_comb begin
    state_nxt = state;
    t_nxt     = '0;
    case (state)
      S_IDLE:  if (start) state_nxt = S_REQ;
      S_REQ:   if (load_ok) state_nxt = S_LATCH;
      S_LATCH: state_nxt = S_FIRE;
      S_FIRE: begin
        t_nxt = t + T_W'(1);
        if (fire_end) state_nxt = S_GAP;
      end
      S_GAP:   if (pri_end) state_nxt = last_aline ? S_IDLE : S_REQ;
      default: state_nxt = S_IDLE;
    endcase
    if (abort) state_nxt = S_IDLE;
  end

  // Delays and shape are captured on the edge into LATCH, so during LATCH they are
  // already stable for max_d and for the first fire bit computed at the LATCH->FIRE edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      t           <= '0;
      pri_cnt     <= '0;
      load_cnt    <= '0;
      d_q         <= '0;
      shape_q     <= '0;
      max_d       <= '0;
      which_aline <= '0;
      aline_done  <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      state      <= state_nxt;
      t          <= t_nxt;
      aline_done <= (state == S_FIRE) && (state_nxt == S_GAP);
      frame_done <= (state == S_GAP) && (state_nxt == S_IDLE) && !abort;

      if ((state == S_REQ) && (state_nxt == S_REQ)) begin
        load_cnt <= cfg_busy ? '0 : load_cnt + LC_W'(1);
      end else begin
        load_cnt <= '0;
      end

      if ((state == S_REQ) && (state_nxt == S_LATCH)) begin
        pri_cnt <= '0;
        d_q     <= ch_delay;
        shape_q <= pulse_shape;
      end else if (pri_cnt != '1) begin
        pri_cnt <= pri_cnt + PRI_W'(1);
      end

      if (state == S_LATCH) max_d <= max_delay(d_q);

      if (state_nxt == S_IDLE) begin
        which_aline <= '0;
      end else if ((state == S_GAP) && (state_nxt == S_REQ)) begin
        which_aline <= which_aline + ALINE_W'(1);
      end
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    channel_pulse_gen u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (fire_en),
      .t       (t_nxt),
      .d       (d_q[i*DELAY_W +: DELAY_W]),
      .shape_q (shape_q),
      .tx      (tx[i])
    );
  end

endmodule

// File: tb/tb_aline_fire_scheduler.sv
// Randomized bench for aline_fire_scheduler; expected tx and timing come from a cycle-offset model.
module tb_aline_fire_scheduler;

  localparam int NCH = 8;
  localparam int DW  = 16;
  localparam int SW  = 32;
  localparam int NA  = 16;
  localparam int PRI = 400;
  localparam int LC  = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic            abort = 1'b0;
  logic            cfg_busy = 1'b0;
  logic [NCH*DW-1:0] ch_delay = '0;
  logic [SW-1:0]   pulse_shape = '0;
  logic [3:0]      which_aline;
  logic [NCH-1:0]  tx;
  logic            busy, aline_done, frame_done;

  int n_vec = 0;
  int n_err = 0;
  int dl[NCH];
  logic [SW-1:0] shp;
  logic [NCH-1:0] exp_q[$];

  aline_fire_scheduler #(
    .NUM_ALINES (NA),
    .ALINE_W    (4),
    .PRI_CYCLES (PRI),
    .LOAD_CYC   (LC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .abort       (abort),
    .cfg_busy    (cfg_busy),
    .ch_delay    (ch_delay),
    .pulse_shape (pulse_shape),
    .which_aline (which_aline),
    .tx          (tx),
    .busy        (busy),
    .aline_done  (aline_done),
    .frame_done  (frame_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_cfg();
    for (int i = 0; i < NCH; i++) ch_delay[i*DW +: DW] = dl[i][DW-1:0];
    pulse_shape = shp;
  endtask

  task automatic rand_cfg(input int dmax);
    for (int i = 0; i < NCH; i++) dl[i] = $urandom_range(0, dmax);
    shp = $urandom;
  endtask

  // Channel c emits shape bit (SW-1-(k-d)) during fire cycle k when d <= k < d+SW.
  function automatic logic [NCH-1:0] exp_tx(input int k);
    logic [NCH-1:0] v;
    v = '0;
    for (int c = 0; c < NCH; c++) begin
      if (k >= dl[c] && k < dl[c] + SW) v[c] = shp[SW-1-(k-dl[c])];
    end
    return v;
  endfunction

  task automatic start_frame();
    start = 1'b1;
    tick();
    start = 1'b0;
    n_vec++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL start_busy: busy=%b required 1", busy);
    end
  endtask

  task automatic do_abort();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_vec++;
    if ({busy, which_aline, tx, aline_done, frame_done} !== 15'd0) begin
      n_err++;
      $display("FAIL abort_idle: busy=%b aline=%0d tx=%h ad=%b fd=%b required all 0",
               busy, which_aline, tx, aline_done, frame_done);
    end
  endtask

  // Entered in the first REQ cycle of A-line idx; leaves in the first cycle after the GAP.
  task automatic check_aline(input int idx, input int busy_hold, input bit jitter, input bit last);
    int md, fire_len, target, off;
    bit bad;
    logic [NCH-1:0] e;
    apply_cfg();
    n_vec++;
    if (which_aline !== 4'(idx)) begin
      n_err++;
      $display("FAIL req_aline: which_aline=%0d required %0d", which_aline, idx);
    end
    cfg_busy = (busy_hold > 0);
    for (int i = 0; i < busy_hold; i++) tick();
    cfg_busy = 1'b0;
    for (int i = 0; i < LC; i++) tick();
    n_vec++;
    if ({busy, tx, aline_done} !== {1'b1, 8'h00, 1'b0}) begin
      n_err++;
      $display("FAIL latch_cycle: busy=%b tx=%h ad=%b required 1/00/0", busy, tx, aline_done);
    end
    md = 0;
    for (int c = 0; c < NCH; c++) if (dl[c] > md) md = dl[c];
    fire_len = md + SW;
    for (int k = 0; k < fire_len; k++) exp_q.push_back(exp_tx(k));
    for (int k = 0; k < fire_len; k++) begin
      tick();
      if (jitter) begin
        cfg_busy = 1'($urandom_range(0, 1));
        start    = 1'($urandom_range(0, 1));
      end
      e = exp_q.pop_front();
      n_vec++;
      if ({tx, aline_done} !== {e, 1'b0}) begin
        n_err++;
        $display("FAIL fire_tx: aline %0d t=%0d tx=%h ad=%b required %h/0", idx, k, tx, aline_done, e);
      end
    end
    cfg_busy = 1'b0;
    start    = 1'b0;
    tick();
    n_vec++;
    if ({aline_done, tx} !== {1'b1, 8'h00}) begin
      n_err++;
      $display("FAIL aline_done: ad=%b tx=%h required 1/00", aline_done, tx);
    end
    off    = fire_len + 1;
    target = (PRI > fire_len + 2) ? PRI : fire_len + 2;
    bad    = 1'b0;
    while (off < target) begin
      if (tx !== '0 || frame_done !== 1'b0 || which_aline !== 4'(idx) || busy !== 1'b1) bad = 1'b1;
      if (off > fire_len + 1 && aline_done !== 1'b0) bad = 1'b1;
      tick();
      off++;
    end
    n_vec++;
    if (bad) begin
      n_err++;
      $display("FAIL gap_quiet: aline %0d outputs active in GAP, required tx=0 no pulses", idx);
    end
    n_vec++;
    if (last) begin
      if ({busy, frame_done, tx} !== {1'b0, 1'b1, 8'h00}) begin
        n_err++;
        $display("FAIL frame_done: busy=%b fd=%b tx=%h required 0/1/00", busy, frame_done, tx);
      end
      tick();
      n_vec++;
      if ({busy, frame_done} !== 2'b00) begin
        n_err++;
        $display("FAIL frame_pulse: busy=%b fd=%b required 0/0", busy, frame_done);
      end
    end else begin
      if ({busy, which_aline, frame_done} !== {1'b1, 4'(idx + 1), 1'b0}) begin
        n_err++;
        $display("FAIL next_req: busy=%b aline=%0d fd=%b required 1/%0d/0",
                 busy, which_aline, frame_done, idx + 1);
      end
    end
  endtask

  task automatic test_reset();
    #12;
    n_vec++;
    if ({tx, busy, which_aline, aline_done, frame_done} !== 15'd0) begin
      n_err++;
      $display("FAIL reset_vals: tx=%h busy=%b aline=%0d ad=%b fd=%b required all 0",
               tx, busy, which_aline, aline_done, frame_done);
    end
    tick();
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < NCH; i++) dl[i] = 0;
    shp = '1;
    apply_cfg();
    start_frame();
    for (int i = 0; i < LC + 4; i++) tick();
    n_vec++;
    if (tx !== 8'hFF) begin
      n_err++;
      $display("FAIL pre_reset_tx: tx=%h required ff", tx);
    end
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({tx, busy, which_aline} !== 13'd0) begin
      n_err++;
      $display("FAIL async_reset: tx=%h busy=%b aline=%0d required all 0", tx, busy, which_aline);
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_abort_start();
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    n_vec++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL abort_prio: busy=%b required 0", busy);
    end
  endtask

  task automatic test_all_zero();
    for (int i = 0; i < NCH; i++) dl[i] = 0;
    shp = 32'hDB000000;
    apply_cfg();
    start_frame();
    check_aline(0, 0, 1'b0, 1'b0);
    do_abort();
  endtask

  task automatic test_mixed_delays();
    for (int i = 0; i < NCH; i++) dl[i] = 3;
    dl[0] = 0;
    dl[1] = 5;
    dl[7] = 100;
    shp = 32'h80000001;
    apply_cfg();
    start_frame();
    check_aline(0, 0, 1'b0, 1'b0);
    do_abort();
  endtask

  task automatic test_cfg_busy();
    rand_cfg(50);
    dl[2] = 0;
    apply_cfg();
    start_frame();
    check_aline(0, 20, 1'b1, 1'b0);
    do_abort();
  endtask

  task automatic test_max_delay();
    rand_cfg(20);
    dl[3] = 16'hFFFF;
    shp = $urandom | 32'h80000001;
    apply_cfg();
    start_frame();
    check_aline(0, 0, 1'b0, 1'b0);
    do_abort();
  endtask

  task automatic test_full_frame();
    bit bad;
    start_frame();
    for (int a = 0; a < NA; a++) begin
      rand_cfg(300);
      check_aline(a, 0, 1'b0, a == NA - 1);
    end
    start_frame();
    for (int a = 0; a < 7; a++) begin
      rand_cfg(300);
      check_aline(a, 0, 1'b0, 1'b0);
    end
    for (int i = 0; i < LC + 5; i++) tick();
    n_vec++;
    if ({busy, which_aline} !== {1'b1, 4'd7}) begin
      n_err++;
      $display("FAIL aline7: busy=%b aline=%0d required 1/7", busy, which_aline);
    end
    do_abort();
    bad = 1'b0;
    for (int i = 0; i < PRI; i++) begin
      tick();
      if (frame_done !== 1'b0 || aline_done !== 1'b0 || busy !== 1'b0 || tx !== '0) bad = 1'b1;
    end
    n_vec++;
    if (bad) begin
      n_err++;
      $display("FAIL post_abort: activity after abort, required idle with no done pulses");
    end
    rand_cfg(300);
    start_frame();
    check_aline(0, 0, 1'b0, 1'b0);
    do_abort();
  endtask

  initial begin
    test_reset();
    test_abort_start();
    test_all_zero();
    test_mixed_delays();
    test_cfg_busy();
    test_max_delay();
    test_full_frame();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
